// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared PC-select encodings, epoch width and fetch FSM states for pc_ctrl
package pc_ctrl_pkg;
  localparam logic PC_SRC1_PC   = 1'b0;
  localparam logic PC_SRC1_XRS1 = 1'b1;
  localparam logic PC_SRC2_4    = 1'b0;
  localparam logic PC_SRC2_IMM  = 1'b1;
  localparam int   EPOCH_W      = 2;
  typedef enum logic [1:0] {PCC_BOOT = 2'd0, PCC_RUN = 2'd1, PCC_PEND = 2'd2} pcc_state_e;
  function automatic logic [EPOCH_W-1:0] epoch_inc(input logic [EPOCH_W-1:0] e);
    return e + EPOCH_W'(1);
  endfunction
endpackage

// File: rtl/pc_target.sv
// pc_target: control-transfer target = base (pc|rs1) + offset (4|imm), JALR bit-0 clear, misalignment flag
//   pc_src1/pc_src2 : base and offset selects
//   pc, rs1, imm    : candidate base operands and immediate
//   target          : computed address (also usable as a link value with pc_src2=PC_SRC2_4)
//   misaligned      : target[1:0] != 0
module pc_target import pc_ctrl_pkg::*; #(
  parameter int XLEN = 64
) (
  input  logic            pc_src1,
  input  logic            pc_src2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);
  logic [XLEN-1:0] base, off, sum;
  always_comb begin
    base       = (pc_src1 == PC_SRC1_XRS1) ? rs1 : pc;
    off        = (pc_src2 == PC_SRC2_IMM) ? imm : XLEN'(4);
    sum        = base + off;
    target     = {sum[XLEN-1:1], sum[0] & (pc_src1 != PC_SRC1_XRS1)};
    misaligned = |target[1:0];
  end
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: owns the fetch PC, issues IFU requests over valid/ready, applies trap/mret/branch redirects with epoch tagging
//   ex_*, x_rs1, imm, pc_src1/2 : EXU control-transfer inputs
//   trap_*, mret_*, mepc        : privileged redirects (trap beats mret beats branch)
//   stall                       : blocks new requests, never drops an outstanding one
//   if_valid/if_pc/if_epoch/if_ready : fetch request handshake
//   flush                       : same-cycle kill pulse on any redirect
//   target_misaligned           : taken branch/jump target not word aligned (no redirect)
module pc_ctrl import pc_ctrl_pkg::*; #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  input  logic               pc_src1,
  input  logic               pc_src2,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic [XLEN-1:0]    x_rs1,
  input  logic [XLEN-1:0]    imm,
  input  logic               trap_valid,
  input  logic [XLEN-1:0]    trap_vec,
  input  logic               mret_valid,
  input  logic [XLEN-1:0]    mepc,
  input  logic               stall,
  output logic               if_valid,
  output logic [XLEN-1:0]    if_pc,
  output logic [EPOCH_W-1:0] if_epoch,
  input  logic               if_ready,
  output logic               flush,
  output logic               target_misaligned
);
  pcc_state_e         state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d, pend_q, pend_d, br_pc, redir_pc;
  logic [EPOCH_W-1:0] epoch_q, epoch_d, cur_q, cur_d;
  logic               valid_q, valid_d, br_mis, br_take, redirect, accept;
  pc_target #(.XLEN(XLEN)) u_tgt (
    .pc_src1   (pc_src1),
    .pc_src2   (pc_src2),
    .pc        (ex_pc),
    .rs1       (x_rs1),
    .imm       (imm),
    .target    (br_pc),
    .misaligned(br_mis)
  );
  // cur_q is the live epoch; if_epoch lags it only while a redirect waits behind a blocked request
  always_comb begin
    br_take  = ex_valid && pc_src2 == PC_SRC2_IMM;
    redirect = trap_valid || mret_valid || (br_take && !br_mis);
    redir_pc = trap_valid ? trap_vec : mret_valid ? mepc : br_pc;
    accept   = valid_q && if_ready;
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    epoch_d  = epoch_q;
    cur_d    = cur_q;
    pend_d   = pend_q;
    case (state_q)
      PCC_BOOT, PCC_RUN: begin
        state_d = PCC_RUN;
        if (valid_q && !if_ready) begin
          if (redirect) begin
            pend_d  = redir_pc;
            cur_d   = epoch_inc(cur_q);
            state_d = PCC_PEND;
          end
        end else begin
          valid_d = state_q == PCC_RUN && !stall;
          pc_d    = redirect ? redir_pc : accept ? pc_q + XLEN'(4) : pc_q;
          epoch_d = redirect ? epoch_inc(cur_q) : cur_q;
          cur_d   = epoch_d;
        end
      end
      PCC_PEND: begin
        if (accept) begin
          valid_d = !stall;
          pc_d    = redirect ? redir_pc : pend_q;
          epoch_d = cur_q;
          state_d = PCC_RUN;
        end else if (redirect) begin
          pend_d = redir_pc;
        end
      end
      default: state_d = PCC_BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PCC_BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= RESET_PC;
      valid_q <= 1'b0;
      epoch_q <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      epoch_q <= epoch_d;
      cur_q   <= cur_d;
    end
  end
  assign if_valid          = valid_q;
  assign if_pc             = pc_q;
  assign if_epoch          = epoch_q;
  assign flush             = rst_n && redirect;
  assign target_misaligned = rst_n && br_take && br_mis;
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed self-checking bench for pc_ctrl
module tb_pc_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ex_valid = 1'b0, pc_src1 = 1'b0, pc_src2 = 1'b0;
  logic [63:0] ex_pc = '0, x_rs1 = '0, imm = '0, trap_vec = '0, mepc = '0;
  logic        trap_valid = 1'b0, mret_valid = 1'b0, stall = 1'b0, if_ready = 1'b1;
  logic        if_valid, flush, target_misaligned;
  logic [63:0] if_pc;
  logic [1:0]  if_epoch;
  int          pass = 0, total = 0;
  pc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .pc_src1(pc_src1), .pc_src2(pc_src2),
    .ex_pc(ex_pc), .x_rs1(x_rs1), .imm(imm), .trap_valid(trap_valid), .trap_vec(trap_vec),
    .mret_valid(mret_valid), .mepc(mepc), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
    .if_epoch(if_epoch), .if_ready(if_ready), .flush(flush), .target_misaligned(target_misaligned)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic branch(input logic [63:0] p, input logic [63:0] i);
    ex_valid = 1'b1; pc_src1 = 1'b0; pc_src2 = 1'b1; ex_pc = p; imm = i;
  endtask
  task automatic quiet;
    ex_valid = 1'b0; trap_valid = 1'b0; mret_valid = 1'b0; pc_src2 = 1'b0;
  endtask
  task automatic test_reset;
    trap_valid = 1'b1; trap_vec = 64'h8000_1000; branch(64'h8000_0010, 64'h12);
    #12;
    total++; if (if_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", if_valid); else pass++;
    total++; if (if_pc !== 64'h8000_0000) $display("FAIL rst_pc: got %h want 8000_0000", if_pc); else pass++;
    total++; if (if_epoch !== 2'd0) $display("FAIL rst_epoch: got %0d want 0", if_epoch); else pass++;
    total++; if (flush !== 1'b0) $display("FAIL rst_flush: got %b want 0", flush); else pass++;
    total++; if (target_misaligned !== 1'b0) $display("FAIL rst_mis: got %b want 0", target_misaligned); else pass++;
    quiet();
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (if_valid !== 1'b0) $display("FAIL boot_valid: got %b want 0", if_valid); else pass++;
    tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 64'h8000_0000) $display("FAIL first_fetch: got %b/%h want 1/8000_0000", if_valid, if_pc); else pass++;
    tick();
    total++; if (if_pc !== 64'h8000_0004) $display("FAIL seq1: got %h want 8000_0004", if_pc); else pass++;
    tick();
    total++; if (if_pc !== 64'h8000_0008 || if_epoch !== 2'd0) $display("FAIL seq2: got %h/%0d want 8000_0008/0", if_pc, if_epoch); else pass++;
  endtask
  task automatic test_branch;
    branch(64'h8000_0010, 64'h20);
    #1;
    total++; if (flush !== 1'b1) $display("FAIL br_flush: got %b want 1", flush); else pass++;
    total++; if (if_epoch !== 2'd0) $display("FAIL br_old_epoch: got %0d want 0", if_epoch); else pass++;
    tick();
    quiet();
    total++; if (if_pc !== 64'h8000_0030 || if_epoch !== 2'd1) $display("FAIL br_target: got %h/%0d want 8000_0030/1", if_pc, if_epoch); else pass++;
  endtask
  task automatic test_jalr_blocked;
    if_ready = 1'b0;
    ex_valid = 1'b1; pc_src1 = 1'b1; pc_src2 = 1'b1; x_rs1 = 64'h8000_0101; imm = 64'h4;
    #1;
    total++; if (flush !== 1'b1) $display("FAIL jalr_flush: got %b want 1", flush); else pass++;
    tick();
    quiet(); pc_src1 = 1'b0; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++; if (if_valid !== 1'b1 || if_pc !== 64'h8000_0030 || if_epoch !== 2'd1) $display("FAIL jalr_hold%0d: got %b/%h/%0d want 1/8000_0030/1", k, if_valid, if_pc, if_epoch); else pass++;
      if (k < 2) tick();
    end
    stall = 1'b0; if_ready = 1'b1;
    tick();
    total++; if (if_pc !== 64'h8000_0104 || if_epoch !== 2'd2) $display("FAIL jalr_target: got %h/%0d want 8000_0104/2", if_pc, if_epoch); else pass++;
  endtask
  task automatic test_trap_priority;
    trap_valid = 1'b1; trap_vec = 64'h8000_1000; branch(64'h8000_0010, 64'h20);
    #1;
    total++; if (flush !== 1'b1) $display("FAIL trap_flush: got %b want 1", flush); else pass++;
    tick();
    total++; if (if_pc !== 64'h8000_1000 || if_epoch !== 2'd3) $display("FAIL trap_target: got %h/%0d want 8000_1000/3", if_pc, if_epoch); else pass++;
    trap_valid = 1'b0; mret_valid = 1'b1; mepc = 64'h8000_2000;
    tick();
    quiet();
    total++; if (if_pc !== 64'h8000_2000 || if_epoch !== 2'd0) $display("FAIL mret_wrap: got %h/%0d want 8000_2000/0", if_pc, if_epoch); else pass++;
  endtask
  task automatic test_misaligned;
    branch(64'h8000_0010, 64'h12);
    #1;
    total++; if (target_misaligned !== 1'b1 || flush !== 1'b0) $display("FAIL mis_flags: got mis=%b flush=%b want 1/0", target_misaligned, flush); else pass++;
    tick();
    quiet();
    total++; if (if_pc !== 64'h8000_2004 || if_epoch !== 2'd0) $display("FAIL mis_seq: got %h/%0d want 8000_2004/0", if_pc, if_epoch); else pass++;
  endtask
  task automatic test_stall;
    stall = 1'b1;
    tick();
    total++; if (if_valid !== 1'b0 || if_pc !== 64'h8000_2008) $display("FAIL stall_drop: got %b/%h want 0/8000_2008", if_valid, if_pc); else pass++;
    branch(64'h8000_0100, 64'h40);
    #1;
    total++; if (flush !== 1'b1) $display("FAIL stall_flush: got %b want 1", flush); else pass++;
    tick();
    quiet();
    total++; if (if_valid !== 1'b0 || if_pc !== 64'h8000_0140 || if_epoch !== 2'd1) $display("FAIL stall_redir: got %b/%h/%0d want 0/8000_0140/1", if_valid, if_pc, if_epoch); else pass++;
    stall = 1'b0;
    tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 64'h8000_0140) $display("FAIL stall_resume: got %b/%h want 1/8000_0140", if_valid, if_pc); else pass++;
  endtask
  task automatic test_pend_overwrite;
    if_ready = 1'b0; branch(64'h8000_0200, 64'h10);
    tick();
    total++; if (if_pc !== 64'h8000_0140 || if_epoch !== 2'd1) $display("FAIL pend_hold: got %h/%0d want 8000_0140/1", if_pc, if_epoch); else pass++;
    branch(64'h8000_0300, 64'h8);
    tick();
    quiet(); if_ready = 1'b1;
    tick();
    total++; if (if_pc !== 64'h8000_0308 || if_epoch !== 2'd2) $display("FAIL pend_overwrite: got %h/%0d want 8000_0308/2", if_pc, if_epoch); else pass++;
  endtask
  task automatic test_reset_pend;
    if_ready = 1'b0; branch(64'h8000_0400, 64'h4);
    tick();
    quiet();
    total++; if (if_pc !== 64'h8000_0308 || if_epoch !== 2'd2) $display("FAIL rp_pend: got %h/%0d want 8000_0308/2", if_pc, if_epoch); else pass++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (if_valid !== 1'b0 || if_pc !== 64'h8000_0000 || if_epoch !== 2'd0) $display("FAIL rp_async: got %b/%h/%0d want 0/8000_0000/0", if_valid, if_pc, if_epoch); else pass++;
    tick();
    rst_n = 1'b1; if_ready = 1'b1;
    tick();
    total++; if (if_valid !== 1'b0) $display("FAIL rp_boot: got %b want 0", if_valid); else pass++;
    tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 64'h8000_0000 || if_epoch !== 2'd0) $display("FAIL rp_restart: got %b/%h/%0d want 1/8000_0000/0", if_valid, if_pc, if_epoch); else pass++;
    tick();
    total++; if (if_pc !== 64'h8000_0004) $display("FAIL rp_seq: got %h want 8000_0004", if_pc); else pass++;
  endtask
  initial begin
    test_reset();
    test_branch();
    test_jalr_blocked();
    test_trap_priority();
    test_misaligned();
    test_stall();
    test_pend_overwrite();
    test_reset_pend();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
